// File: rtl/pipe_arb_pkg.sv
// Shared helpers for the round-robin pipeline arbiter.
package pipe_arb_pkg;

  // Requester-index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_pick
  import pipe_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] g
);

  assign any = |req;

  always_comb begin : pick
    int unsigned idx;
    logic        found;
    g     = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        g     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding a fixed-latency, enable-gated register pipeline.
// Define PIPE_ARB_BUBBLE_COLLAPSE_EN to let empty stages advance under a stalled tail.
module pipe_rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16,
  parameter int unsigned L  = 4,
  localparam int unsigned IW = id_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0][DW-1:0] req_data,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [IW-1:0]        out_id,
  output logic                 busy
);

  logic [L-1:0]          v;
  logic [L-1:0]          en;
  logic [L-1:0][IW-1:0]  id;
  logic [L-1:0][DW-1:0]  d;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         g;
  logic                  any;
  logic                  acc;

  rr_pick #(.N(N)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (any),
    .g   (g)
  );

`ifdef PIPE_ARB_BUBBLE_COLLAPSE_EN
  // Each stage advances if it is empty or the stage ahead of it advances.
  always_comb begin : stage_en
    logic run;
    run = !v[L-1] || out_ready;
    en  = '0;
    for (int k = int'(L) - 1; k >= 0; k--) begin
      if (k < int'(L) - 1) run = !v[k] || run;
      en[k] = run;
    end
  end
`else
  // Whole pipe shifts or freezes together on the tail's handshake.
  always_comb begin
    en = {L{!v[L-1] || out_ready}};
  end
`endif

  assign acc = any && en[0] && !rst;

  always_comb begin
    req_ready = '0;
    if (acc) req_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      id  <= '0;
      d   <= '0;
      ptr <= '0;
    end else begin
      if (en[0]) v[0] <= acc;
      if (acc) begin
        id[0] <= g;
        d[0]  <= req_data[g];
        ptr   <= IW'((32'(g) + 32'd1) % N);
      end
      for (int k = 1; k < int'(L); k++) begin
        if (en[k]) begin
          v[k]  <= v[k-1];
          id[k] <= id[k-1];
          d[k]  <= d[k-1];
        end
      end
    end
  end

  assign out_valid = v[L-1];
  assign out_id    = id[L-1];
  assign out_data  = d[L-1];
  assign busy      = |v;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed bench for pipe_rr_arbiter with an accept-order scoreboard.
module tb_pipe_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned L  = 4;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] d;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]         req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [IW-1:0]        out_id;
  logic                 busy;

  pipe_rr_arbiter #(.N(N), .DW(DW), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t          sb[$];
  logic [IW-1:0] out_log[$];
  logic [L-1:0]  mv = '0;
  int            mptr = 0;
  logic [N-1:0]  last_rr;
  logic          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic cycle();
    logic [L-1:0] en;
    logic [N-1:0] exp_rr;
    logic         run, any, acc;
    int           g;
    exp_t         e;
    @(negedge clk);
    any = |req_valid;
    g   = 0;
    for (int k = int'(N) - 1; k >= 0; k--)
      if (req_valid[(mptr + k) % N]) g = (mptr + k) % N;
    run = !mv[L-1] || out_ready;
    for (int k = int'(L) - 1; k >= 0; k--) begin
`ifdef PIPE_ARB_BUBBLE_COLLAPSE_EN
      if (k < int'(L) - 1) run = !mv[k] || run;
`endif
      en[k] = run;
    end
    acc    = any && en[0] && !rst;
    exp_rr = acc ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("out_valid", 32'(out_valid), 32'(mv[L-1]));
    chk("busy", 32'(busy), 32'(|mv));
    if (mv[L-1] && sb.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(sb[0].d));
      chk("out_id", 32'(out_id), 32'(sb[0].id));
    end
    last_rr  = req_ready;
    last_acc = acc;
    if (out_valid && out_ready) out_log.push_back(out_id);
    if (rst) begin
      mv   = '0;
      mptr = 0;
      sb.delete();
    end else begin
      if (mv[L-1] && out_ready && sb.size() > 0) void'(sb.pop_front());
      for (int k = int'(L) - 1; k >= 1; k--) if (en[k]) mv[k] = mv[k-1];
      if (en[0]) mv[0] = acc;
      if (acc) begin
        e.id = IW'(g);
        e.d  = req_data[g];
        sb.push_back(e);
        mptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single word from requester 2, visible exactly L cycles later for one cycle.
    out_ready   = 1'b1;
    req_data[2] = 16'h00AA;
    req_valid   = 4'b0100;
    cycle();
    chk("t1_grant", 32'(last_rr), 32'h4);
    req_valid = '0;
    for (int i = 0; i < int'(L) - 1; i++) cycle();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h00AA);
    chk("t1_id", 32'(out_id), 32'd2);
    cycle();
    chk("t1_one_cycle", 32'(out_valid), 32'd0);

    // Fairness: all requesters valid, one output per cycle, ids cycle 0..3.
    do_reset();
    out_log.delete();
    for (int i = 0; i < int'(N); i++) req_data[i] = DW'(16'h1000 + i);
    req_valid = '1;
    for (int i = 0; i < 16; i++) cycle();
    drain(L);
    chk("t2_count", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < out_log.size(); i++) chk("t2_order", 32'(out_log[i]), 32'(i % N));

    // Pointer skip over idle requesters; ptr holds across an idle cycle.
    do_reset();
    req_valid = 4'b1010;
    cycle(); chk("t3_g0", 32'(last_rr), 32'h2);
    cycle(); chk("t3_g1", 32'(last_rr), 32'h8);
    req_valid = '0;
    cycle(); chk("t3_idle", 32'(last_rr), 32'h0);
    req_valid = 4'b1010;
    cycle(); chk("t3_g2", 32'(last_rr), 32'h2);
    cycle(); chk("t3_g3", 32'(last_rr), 32'h8);
    drain(L + 1);

`ifndef PIPE_ARB_BUBBLE_COLLAPSE_EN
    // Global stall: tail frozen, no accepts, then in-order resume.
    do_reset();
    out_ready   = 1'b1;
    req_data[0] = 16'h0001;
    req_valid   = 4'b0001;
    for (int i = 0; i < 10 && !out_valid; i++) begin
      cycle();
      if (last_acc) req_data[0] = req_data[0] + 16'd1;
    end
    chk("t4_first_valid", 32'(out_valid), 32'd1);
    chk("t4_first_data", 32'(out_data), 32'h0001);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_frozen", 32'(out_data), 32'h0001);
      chk("t4_no_accept", 32'(last_rr), 32'h0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_acc) req_data[0] = req_data[0] + 16'd1;
    end
    drain(L + 1);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
`else
    // Bubble collapse: stalled tail, three more accepts fill the pipe, then drain back to back.
    do_reset();
    out_ready   = 1'b1;
    req_data[0] = 16'h0050;
    req_valid   = 4'b0001;
    cycle();
    req_valid = '0;
    for (int i = 0; i < int'(L) - 1; i++) cycle();
    chk("t5_tail", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    req_valid = 4'b0001;
    for (int i = 0; i < int'(L) + 1; i++) begin
      req_data[0] = DW'(16'h0060 + i);
      cycle();
      chk("t5_accept", 32'(last_rr), (i < int'(L) - 1) ? 32'h1 : 32'h0);
    end
    req_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < int'(L); i++) begin
      chk("t5_b2b", 32'(out_valid), 32'd1);
      cycle();
    end
    chk("t5_empty", 32'(out_valid), 32'd0);
`endif

    // Reset with words in flight: everything discarded, ptr back to 0.
    do_reset();
    out_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 3; i++) cycle();
    do_reset();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    for (int i = 0; i < int'(L) + 2; i++) begin
      cycle();
      chk("t6_no_stale", 32'(out_valid), 32'd0);
    end
    req_valid = '1;
    cycle();
    chk("t6_grant0", 32'(last_rr), 32'h1);
    drain(L + 1);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_rr_arbiter.md
# pipe_rr_arbiter

Shares one fixed-latency, enable-gated register pipeline between N requesters. Arbitration is round-robin. Each accepted word carries its requester ID alongside the data. A single valid/ready port at the output applies backpressure by stalling the pipeline. It sits in front of shared delay/compute stages wherever several producers feed one datapath whose latency must stay fixed at L cycles when unstalled.

## Interface
Parameters:
- N, 4: number of requesters (≥2)
- DW, 16: data width
- L, 4: pipeline depth in register stages (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N  per-requester valid
- req_data  in  N×DW  per-requester data, packed [N-1:0][DW-1:0]
- req_ready  out  N  per-requester accept; at most one bit high
- out_valid  out  1  pipeline tail holds a word
- out_ready  in  1  consumer accepts tail word
- out_data  out  DW  tail data
- out_id  out  IW  tail requester index, IW = max(1, $clog2(N))
- busy  out  1  any stage valid

## Operation
- Each stage k in 0..L-1 holds three fields: v[k], id[k] and d[k]. The tail is stage L-1, and out_* map directly to its fields.
- Stage enable en[k] is defined by configuration (see below). Input stage enable is en[0].
- Grant:
  - g = first i with req_valid[i], searching cyclically from pointer ptr.
  - any = OR of req_valid.
- Accept: acc = any && en[0]; req_ready[g] = acc. req_ready is combinational from req_valid, ptr and en[0].
- On acc:
  - stage 0 loads v=1, id=g, d=req_data[g];
  - ptr <= (g+1) mod N.
- On en[0] && !any: stage 0 loads v=0 and ptr holds.
- Stage k>0 with en[k] loads stage k-1. A disabled stage holds its contents.
- A tail word is consumed when out_valid && out_ready.
- ptr moves only on acc. A requester dropping req_valid before it is accepted is legal and is not a protocol error.
- Reset: all v, id, d and ptr are cleared to 0.
- Output reset values: out_valid=0, out_data=0, out_id=0, req_ready=0, busy=0.
- Reset asserted mid-operation discards all in-flight words with no output.

## Timing
- Latency: a word accepted at edge t appears with out_valid=1 after edge t+L-1, i.e. in cycle t+L, provided there are no stalls.
- Throughput: one word per cycle with out_ready held high.
- Stall: out_valid && !out_ready holds the tail. The tail word, out_data and out_id stay stable until consumed.
- No combinational path from req_valid to out_*.
- There is a combinational path from out_ready to req_ready.
- Simultaneous consume at the tail and accept at the input in one cycle is allowed whenever en[0].
- N=1 is not supported. L=1 means stage 0 is the tail.

## Configuration
- Macro PIPE_ARB_BUBBLE_COLLAPSE_EN.
- Undefined (global stall): every stage uses en[k] = !v[L-1] || out_ready. The whole pipe, bubbles included, shifts or freezes together.
- Defined (bubble collapse):
  - en[L-1] = !v[L-1] || out_ready;
  - en[k] = !v[k] || en[k+1].
  - An empty stage always accepts, so bubbles are squeezed out while the tail is stalled.
- With bubbles collapsed, up to L words can be accepted while out_ready=0. Unstalled latency and output order are identical in both modes.

## Structure
- Package pipe_arb_pkg holds the function id_width(N) returning max(1, $clog2(N)).
- Sub-module rr_pick(N) is a combinational round-robin picker. Inputs: req, ptr. Outputs: any, g. It is purely combinational.
- Stages are held in packed arrays in the top module.

## Test plan
Parameters for all scenarios: N=4, L=4, DW=16.

- Single word: requester 2 sends 0x00AA with out_ready=1. Expect req_ready[2] in the same cycle, then out_valid with out_data=0x00AA and out_id=2 exactly 4 cycles later, for 1 cycle.
- Fairness: all four valid continuously with out_ready=1. Expect out_id sequence 0,1,2,3,0,1,… with one output per cycle and no gaps.
- Pointer skip: requesters 1 and 3 valid, starting from ptr=0. Expect grants 1,3,1,3; ptr holds on idle cycles.
- Backpressure in global-stall mode: only requester 0 valid, feeding 0x0001, 0x0002, …. After the first output appears, drop out_ready for 5 cycles. Expect:
  - out_data frozen at 0x0001;
  - req_ready=0 throughout;
  - stream resumes in order with no loss or duplicate.
- Bubble collapse (PIPE_ARB_BUBBLE_COLLAPSE_EN): one word in flight, tail stalled. Expect 3 further accepts, then req_ready=0. On out_ready=1, expect 4 back-to-back outputs.
- Reset mid-flight: three words in flight, rst=1 for 1 cycle. Expect:
  - out_valid=0 and busy=0 the next cycle;
  - no stale output afterwards;
  - the next grant goes to requester 0.
